// File: rtl/seg_pkg.sv
// Shared types, hex segment table and polarity helper for the seven-segment scan driver.
package seg_pkg;

    typedef logic [7:0] seg_t;

    // Active-high a..g patterns; bit 7 (dp) is always clear here.
    localparam seg_t SEG_HEX [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    localparam seg_t SEG_OFF_H = 8'h00;

    function automatic seg_t seg_polarity(input seg_t s, input bit active_low);
        return active_low ? ~s : s;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble + decimal point to active-high segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output seg_t       o_seg
);

    assign o_seg = SEG_HEX[i_nibble] | {i_dp, 7'b0000000};

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: prescaled digit scan, double-buffered
// display data committed on frame boundaries, blanking and leading-zero suppression.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_DIV    = 100000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam bit SEG_AL = (SEG_ACTIVE_LOW != 0);
    localparam bit AN_AL  = (AN_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_AL ? '1 : '0;

    logic [PW-1:0]           r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_data, r_act_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp, r_pend_blank, r_act_dp, r_act_blank;
    logic                    r_pending, r_frame_done;
    seg_t                    r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [IDX_W-1:0]        r_didx;

    logic                    w_tick, w_last, w_commit;
    logic [3:0]              w_nib;
    seg_t                    w_dec;
    logic [NUM_DIGITS-1:0]   w_zero, w_lz, w_dark, w_onehot;
    logic                    w_run, w_cur_dark;

    assign w_tick   = enable && (r_presc == PW'(REFRESH_DIV - 1));
    assign w_last   = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_commit = w_last || !enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else if (!enable) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // A load coinciding with a commit still lets the previous pending data through first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (w_commit && r_pending) begin
                r_act_data  <= r_pend_data;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= r_pend_blank;
            end
            if (load) begin
                r_pend_data  <= data_in;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank_in;
                r_pending    <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Suppression runs from the top digit down and stops at the first significant one.
    always_comb begin
        w_zero = '0;
        w_lz   = '0;
        w_run  = lz_suppress;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            w_zero[k] = (r_act_data[4*k +: 4] == 4'h0) && !r_act_dp[k];
        end
        for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_run   = w_run && w_zero[k];
            w_lz[k] = w_run;
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
    end

    assign w_dark     = r_act_blank | w_lz;
    assign w_cur_dark = w_dark[r_idx];
    assign w_nib      = r_act_data[{r_idx, 2'b00} +: 4];

    seg_hex_decode u_decode (
        .i_nibble (w_nib),
        .i_dp     (r_act_dp[r_idx]),
        .o_seg    (w_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg  <= seg_polarity(SEG_OFF_H, SEG_AL);
            r_an   <= AN_OFF;
            r_didx <= '0;
        end else begin
            r_didx <= enable ? r_idx : '0;
            if (!enable || w_cur_dark) begin
                r_seg <= seg_polarity(SEG_OFF_H, SEG_AL);
                r_an  <= AN_OFF;
            end else begin
                r_seg <= seg_polarity(w_dec, SEG_AL);
                r_an  <= AN_AL ? ~w_onehot : w_onehot;
            end
        end
    end

    assign seg_out    = r_seg;
    assign an_out     = r_an;
    assign digit_idx  = r_didx;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: decoder table, directed frame sequences and random stimulus vs a frame-level model.
module tb_seg_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0, load = 1'b0, lz_suppress = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0, blank_in = '0;

    logic [7:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;
    logic [1:0]  idx_a, idx_b;
    logic        fd_a, fd_b, pend_a, pend_b;

    logic [3:0]  dec_nib = '0;
    logic        dec_dp = 1'b0;
    logic [7:0]  dec_seg;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .lz_suppress(lz_suppress), .seg_out(seg_a), .an_out(an_a),
        .digit_idx(idx_a), .frame_done(fd_a), .pending(pend_a));

    seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .lz_suppress(lz_suppress), .seg_out(seg_b), .an_out(an_b),
        .digit_idx(idx_b), .frame_done(fd_b), .pending(pend_b));

    seg_hex_decode u_dec (.i_nibble(dec_nib), .i_dp(dec_dp), .o_seg(dec_seg));

    logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    typedef struct {
        logic [3:0] nib;
        logic       dp;
        logic [7:0] seg;
    } dec_vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: cycles since enable, committed and pending frame contents.
    int          m_cnt;
    logic [15:0] m_ad, m_pd;
    logic [3:0]  m_adp, m_ab, m_pdp, m_pb;
    bit          m_pf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_ad = '0; m_pd = '0; m_adp = '0; m_ab = '0; m_pdp = '0; m_pb = '0; m_pf = 1'b0;
    endtask

    task automatic cyc(input bit en, input bit ld, input logic [15:0] d, input logic [3:0] dp,
                       input logic [3:0] bl, input bit lz);
        int idxm, msd;
        bit last, dark, commit;
        logic [7:0] sh, e_sa, e_sb;
        logic [3:0] oh, e_aa, e_ab;
        @(negedge clk);
        enable = en; load = ld; data_in = d; dp_in = dp; blank_in = bl; lz_suppress = lz;
        @(posedge clk);
        idxm = (m_cnt / DIV) % N;
        last = en && (m_cnt % DIV == DIV - 1) && (idxm == N - 1);
        msd = 0;
        for (int k = 0; k < N; k++)
            if (m_ad[4*k +: 4] != 4'h0 || m_adp[k]) msd = k;
        dark = m_ab[idxm] || (lz && idxm > msd);
        sh = hex_tab[m_ad[4*idxm +: 4]] | {m_adp[idxm], 7'b0000000};
        oh = 4'(1 << idxm);
        if (!en || dark) begin
            e_sa = 8'hFF; e_aa = 4'hF; e_sb = 8'h00; e_ab = 4'h0;
        end else begin
            e_sa = ~sh; e_aa = ~oh; e_sb = sh; e_ab = oh;
        end
        commit = !en || last;
        if (commit && m_pf) begin
            m_ad = m_pd; m_adp = m_pdp; m_ab = m_pb;
        end
        if (ld) begin
            m_pd = d; m_pdp = dp; m_pb = bl; m_pf = 1'b1;
        end else if (commit) begin
            m_pf = 1'b0;
        end
        m_cnt = en ? m_cnt + 1 : 0;
        #1;
        chk("seg_a", seg_a, e_sa);
        chk("an_a", an_a, e_aa);
        chk("idx_a", idx_a, en ? idxm : 0);
        chk("frame_done_a", fd_a, last);
        chk("pending_a", pend_a, m_pf);
        chk("seg_b", seg_b, e_sb);
        chk("an_b", an_b, e_ab);
        chk("pending_b", pend_b, m_pf);
        chk("frame_done_b", fd_b, last);
        chk("idx_b", idx_b, en ? idxm : 0);
    endtask

    // Loads with the scan stopped (commits immediately), then scans one frame checking each slot.
    task automatic frame(input string name, input logic [15:0] d, input logic [3:0] dp, input bit lz,
                         input logic [31:0] es, input logic [15:0] ea);
        cyc(0, 1, d, dp, 4'h0, lz);
        cyc(0, 0, d, dp, 4'h0, lz);
        for (int s = 0; s < N; s++) begin
            for (int c = 0; c < DIV; c++) begin
                cyc(1, 0, d, dp, 4'h0, lz);
                chk({name, "_seg"}, seg_a, es[8*s +: 8]);
                chk({name, "_an"}, an_a, ea[4*s +: 4]);
            end
        end
        chk({name, "_fd"}, fd_a, 1);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_seg_a"}, seg_a, 8'hFF);
        chk({name, "_an_a"}, an_a, 4'hF);
        chk({name, "_idx_a"}, idx_a, 0);
        chk({name, "_pend_a"}, pend_a, 0);
        chk({name, "_fd_a"}, fd_a, 0);
        chk({name, "_seg_b"}, seg_b, 8'h00);
        chk({name, "_an_b"}, an_b, 4'h0);
    endtask

    initial begin
        dec_vec_t tbl [20];
        tbl = '{'{4'h0, 1'b0, 8'h3F}, '{4'h1, 1'b0, 8'h06}, '{4'h2, 1'b0, 8'h5B}, '{4'h3, 1'b0, 8'h4F},
                '{4'h4, 1'b0, 8'h66}, '{4'h5, 1'b0, 8'h6D}, '{4'h6, 1'b0, 8'h7D}, '{4'h7, 1'b0, 8'h07},
                '{4'h8, 1'b0, 8'h7F}, '{4'h9, 1'b0, 8'h6F}, '{4'hA, 1'b0, 8'h77}, '{4'hB, 1'b0, 8'h7C},
                '{4'hC, 1'b0, 8'h39}, '{4'hD, 1'b0, 8'h5E}, '{4'hE, 1'b0, 8'h79}, '{4'hF, 1'b0, 8'h71},
                '{4'h0, 1'b1, 8'hBF}, '{4'h8, 1'b1, 8'hFF}, '{4'h7, 1'b1, 8'h87}, '{4'hF, 1'b1, 8'hF1}};
        for (int i = 0; i < 20; i++) begin
            dec_nib = tbl[i].nib;
            dec_dp  = tbl[i].dp;
            #1;
            chk("hex_decode", dec_seg, tbl[i].seg);
        end

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Scan order and frame_done cadence
        frame("scan", 16'h1234, 4'h0, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}, {4'h7, 4'hB, 4'hD, 4'hE});

        // Tear-free update: load during digit 1, old frame completes first
        while (m_cnt % (N*DIV) != 4) cyc(1, 0, 16'h1234, 4'h0, 4'h0, 1'b0);
        cyc(1, 1, 16'hABCD, 4'h0, 4'h0, 1'b0);
        chk("tear_pending", pend_a, 1);
        while (m_cnt % (N*DIV) != 0) cyc(1, 0, 16'hABCD, 4'h0, 4'h0, 1'b0);
        chk("tear_commit_pending", pend_a, 0);
        cyc(1, 0, 16'hABCD, 4'h0, 4'h0, 1'b0);
        chk("tear_new_digit0", seg_a, 8'hA1);

        // Load coinciding with the final-digit commit tick
        cyc(1, 1, 16'h1111, 4'h0, 4'h0, 1'b0);
        while (m_cnt % (N*DIV) != N*DIV - 1) cyc(1, 0, 16'h1111, 4'h0, 4'h0, 1'b0);
        cyc(1, 1, 16'h5555, 4'h0, 4'h0, 1'b0);
        chk("simul_pending", pend_a, 1);
        cyc(1, 0, 16'h5555, 4'h0, 4'h0, 1'b0);
        chk("simul_old_digit0", seg_a, 8'hF9);
        while (m_cnt % (N*DIV) != 0) cyc(1, 0, 16'h5555, 4'h0, 4'h0, 1'b0);
        chk("simul_commit_pending", pend_a, 0);
        cyc(1, 0, 16'h5555, 4'h0, 4'h0, 1'b0);
        chk("simul_new_digit0", seg_a, 8'h92);

        // Leading-zero suppression and decimal point
        frame("lz", 16'h0070, 4'h0, 1'b1, {8'hFF, 8'hFF, 8'hF8, 8'hC0}, {4'hF, 4'hF, 4'hD, 4'hE});
        frame("lz_dp", 16'h0070, 4'h4, 1'b1, {8'hFF, 8'h40, 8'hF8, 8'hC0}, {4'hF, 4'hB, 4'hD, 4'hE});

        // Disable: outputs dark next edge, pending commits immediately
        cyc(1, 1, 16'h00AB, 4'h0, 4'h0, 1'b0);
        chk("dis_pending_set", pend_a, 1);
        cyc(0, 0, 16'h00AB, 4'h0, 4'h0, 1'b0);
        chk("dis_seg", seg_a, 8'hFF);
        chk("dis_an", an_a, 4'hF);
        chk("dis_idx", idx_a, 0);
        chk("dis_pending_clr", pend_a, 0);

        // Active-high polarity build
        cyc(0, 1, 16'h0008, 4'h0, 4'h0, 1'b0);
        cyc(0, 0, 16'h0008, 4'h0, 4'h0, 1'b0);
        cyc(1, 0, 16'h0008, 4'h0, 4'h0, 1'b0);
        chk("pol_seg_b", seg_b, 8'h7F);
        chk("pol_an_b", an_b, 4'h1);
        chk("pol_seg_a", seg_a, 8'h80);
        chk("pol_an_a", an_a, 4'hE);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] mask, d;
            logic [3:0]  bl;
            case ($urandom_range(0, 3))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                default: mask = 16'h000F;
            endcase
            d  = 16'($urandom) & mask;
            bl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            cyc($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0, d,
                ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), bl, $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset mid-frame with data pending
        while (m_cnt < 6) cyc(1, 0, 16'h0000, 4'h0, 4'h0, 1'b0);
        cyc(1, 1, 16'h9876, 4'h0, 4'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        @(negedge clk);
        enable = 1'b0;
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2*N*DIV; i++) cyc(1, 0, 16'h4321, 4'h0, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
